// File: rtl/error_injection_pkg.sv
// -----------------------------------------------------------------------------
// error_injection_pkg
// Shared definitions for the error injection sequencer:
//   - seq_state_e : sequencer FSM states (IDLE, CALC, DONE)
//   - acc_width() : full-precision accumulator width for one injection sample
//   - saturate()  : clamp a signed value to a signed range of 'width' bits
// -----------------------------------------------------------------------------
package error_injection_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // Headroom: product of tap and symbol, x2, x3 for NRZ scaling, plus the
    // growth from summing 'depth' terms.
    function automatic int acc_width(input int ch_w, input int br_w, input int depth);
        return ch_w + br_w + 3 + $clog2(depth);
    endfunction

    // Works on a 64-bit container so one function serves every output width;
    // callers keep the low 'width' bits of the result.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                    input int                width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/injection_pattern_mac.sv
// -----------------------------------------------------------------------------
// injection_pattern_mac
// Combinational multiply-accumulate for one trellis pattern. Produces the
// seq_length full-precision normal sums
//   S[j] = sum_k scale * pattern[k] * 2 * channel[cp - k + j]
// where a term exists only if its channel index lies inside the tap vector.
//
// Ports:
//   channel  : tap i at [i*est_channel_bitwidth +: est_channel_bitwidth], signed
//   pattern  : symbol k at [k*branch_bitwidth +: branch_bitwidth], signed
//   nrz_mode : 1 -> scale 3, 0 -> scale 1
//   sums     : sample j at [j*ACC_W +: ACC_W], signed, full precision
// -----------------------------------------------------------------------------
module injection_pattern_mac
    import error_injection_pkg::*;
#(
    parameter int seq_length            = 3,
    parameter int trellis_pattern_depth = 3,
    parameter int branch_bitwidth       = 2,
    parameter int est_channel_bitwidth  = 8,
    parameter int cp                    = 2,
    localparam int N_TAPS = seq_length + trellis_pattern_depth - 1,
    localparam int ACC_W  = acc_width(est_channel_bitwidth, branch_bitwidth,
                                      trellis_pattern_depth)
) (
    input  logic [N_TAPS*est_channel_bitwidth-1:0]          channel,
    input  logic [trellis_pattern_depth*branch_bitwidth-1:0] pattern,
    input  logic                                            nrz_mode,
    output logic [seq_length*ACC_W-1:0]                     sums
);

    logic signed [branch_bitwidth-1:0]      sym;
    logic signed [est_channel_bitwidth-1:0] tap;
    logic signed [ACC_W-1:0]                gain;
    logic signed [ACC_W-1:0]                acc;
    int                                     idx;

    // NOTE: every variable driven here gets a value before any branch, so no
    // path can leave one unassigned and infer a latch.
    always_comb begin
        sums = '0;
        sym  = '0;
        tap  = '0;
        acc  = '0;
        idx  = 0;
        // scale * 2 folded into a single gain
        gain = nrz_mode ? ACC_W'(6) : ACC_W'(2);
        for (int j = 0; j < seq_length; j++) begin
            acc = '0;
            for (int k = 0; k < trellis_pattern_depth; k++) begin
                idx = cp - k + j;
                if (idx >= 0 && idx <= N_TAPS - 1) begin
                    sym = pattern[k*branch_bitwidth +: branch_bitwidth];
                    tap = channel[idx*est_channel_bitwidth +: est_channel_bitwidth];
                    acc = acc + ACC_W'(sym) * ACC_W'(tap) * gain;
                end
            end
            sums[j*ACC_W +: ACC_W] = acc;
        end
    end

endmodule

// File: rtl/error_injection_sequencer.sv
// -----------------------------------------------------------------------------
// error_injection_sequencer
// Generates the normal and polarity-inverted signed error sequences for every
// trellis pattern of a transaction, one pattern per clock, and presents the
// registered result bank with a saturation flag.
//
// Ports:
//   clk, rstb            : clock, asynchronous active-low reset
//   in_valid / in_ready  : request handshake; in_ready is high only in IDLE
//   channel              : tap i at [i*est_channel_bitwidth +: est_channel_bitwidth]
//   trellis_patterns     : pattern p symbol k at
//                          [(p*trellis_pattern_depth + k)*branch_bitwidth +: branch_bitwidth]
//   pattern_enable       : bit p enables pattern p
//   nrz_mode             : scale 3 when set, 1 otherwise
//   out_valid / out_ready: result handshake; out_valid is high only in DONE
//   injection_error_seqs : row r sample j at
//                          [(r*seq_length + j)*est_err_bitwidth +: est_err_bitwidth];
//                          row 2p = normal, row 2p+1 = inverted for pattern p
//   sat_flag             : some result of the current bank was clipped
// All data inputs are captured on accept; later changes are ignored.
// -----------------------------------------------------------------------------
module error_injection_sequencer
    import error_injection_pkg::*;
#(
    parameter int seq_length              = 3,
    parameter int trellis_pattern_depth   = 3,
    parameter int num_of_trellis_patterns = 3,
    parameter int branch_bitwidth         = 2,
    parameter int est_channel_bitwidth    = 8,
    parameter int est_err_bitwidth        = 9,
    parameter int cp                      = 2,
    localparam int N_TAPS   = seq_length + trellis_pattern_depth - 1,
    localparam int CH_VEC_W = N_TAPS * est_channel_bitwidth,
    localparam int PAT_W    = trellis_pattern_depth * branch_bitwidth,
    localparam int PATS_W   = num_of_trellis_patterns * PAT_W,
    localparam int ROW_W    = seq_length * est_err_bitwidth,
    localparam int BANK_W   = 2 * num_of_trellis_patterns * ROW_W
) (
    input  logic                               clk,
    input  logic                               rstb,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [CH_VEC_W-1:0]                channel,
    input  logic [PATS_W-1:0]                  trellis_patterns,
    input  logic [num_of_trellis_patterns-1:0] pattern_enable,
    input  logic                               nrz_mode,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [BANK_W-1:0]                  injection_error_seqs,
    output logic                               sat_flag
);

    localparam int ACC_W = acc_width(est_channel_bitwidth, branch_bitwidth,
                                     trellis_pattern_depth);
    localparam int CNT_W = (num_of_trellis_patterns > 1) ? $clog2(num_of_trellis_patterns) : 1;

    seq_state_e state;
    seq_state_e state_next;
    logic       accept;
    logic       last_pattern;

    logic [CNT_W-1:0]                   p_cnt;
    logic [CH_VEC_W-1:0]                ch_q;
    logic [PATS_W-1:0]                  pat_q;
    logic [num_of_trellis_patterns-1:0] en_q;
    logic                               nrz_q;
    logic [BANK_W-1:0]                  bank_q;
    logic                               sat_q;

    logic [PAT_W-1:0]            pat_sel;
    logic [seq_length*ACC_W-1:0] sums;
    logic [ROW_W-1:0]            norm_row;
    logic [ROW_W-1:0]            inv_row;
    logic                        row_clip;

    logic signed [ACC_W-1:0] acc_j;
    logic signed [63:0]      norm_full;
    logic signed [63:0]      inv_full;
    logic signed [63:0]      norm_sat;
    logic signed [63:0]      inv_sat;

    assign last_pattern = (p_cnt == CNT_W'(num_of_trellis_patterns - 1));

    // ---------------- FSM ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (last_pattern) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- Datapath ----------------
    always_comb begin
        pat_sel = pat_q[int'(p_cnt)*PAT_W +: PAT_W];
    end

    injection_pattern_mac #(
        .seq_length            (seq_length),
        .trellis_pattern_depth (trellis_pattern_depth),
        .branch_bitwidth       (branch_bitwidth),
        .est_channel_bitwidth  (est_channel_bitwidth),
        .cp                    (cp)
    ) u_mac (
        .channel  (ch_q),
        .pattern  (pat_sel),
        .nrz_mode (nrz_q),
        .sums     (sums)
    );

    // Negate at full precision first, then clamp each row on its own, so the
    // inverted row reaches the negative rail even when the normal row clips high.
    always_comb begin
        norm_row  = '0;
        inv_row   = '0;
        row_clip  = 1'b0;
        acc_j     = '0;
        norm_full = '0;
        inv_full  = '0;
        norm_sat  = '0;
        inv_sat   = '0;
        for (int j = 0; j < seq_length; j++) begin
            acc_j     = sums[j*ACC_W +: ACC_W];
            norm_full = 64'(acc_j);
            inv_full  = -norm_full;
            norm_sat  = saturate(norm_full, est_err_bitwidth);
            inv_sat   = saturate(inv_full, est_err_bitwidth);
            norm_row[j*est_err_bitwidth +: est_err_bitwidth] = norm_sat[est_err_bitwidth-1:0];
            inv_row[j*est_err_bitwidth +: est_err_bitwidth]  = inv_sat[est_err_bitwidth-1:0];
            row_clip = row_clip | (norm_sat != norm_full) | (inv_sat != inv_full);
        end
    end

    // NOTE: the result bank is reset explicitly because its all-zero value is
    // visible on the outputs; it is also wiped on accept so no partial bank
    // from an earlier transaction can be read as valid.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            p_cnt  <= '0;
            ch_q   <= '0;
            pat_q  <= '0;
            en_q   <= '0;
            nrz_q  <= 1'b0;
            bank_q <= '0;
            sat_q  <= 1'b0;
        end else if (accept) begin
            p_cnt  <= '0;
            ch_q   <= channel;
            pat_q  <= trellis_patterns;
            en_q   <= pattern_enable;
            nrz_q  <= nrz_mode;
            bank_q <= '0;
            sat_q  <= 1'b0;
        end else if (state == CALC) begin
            // A disabled pattern still spends its cycle so latency is mask-independent.
            bank_q[(2*int'(p_cnt))*ROW_W +: ROW_W]   <= en_q[p_cnt] ? norm_row : '0;
            bank_q[(2*int'(p_cnt)+1)*ROW_W +: ROW_W] <= en_q[p_cnt] ? inv_row  : '0;
            sat_q <= sat_q | (en_q[p_cnt] & row_clip);
            p_cnt <= last_pattern ? '0 : p_cnt + CNT_W'(1);
        end
    end

    assign injection_error_seqs = bank_q;
    assign sat_flag             = sat_q;

endmodule

// File: tb/tb_error_injection_sequencer.sv
// -----------------------------------------------------------------------------
// tb_error_injection_sequencer
// Directed and random transactions against a behavioural model that evaluates
// the injection sum directly over integer arrays.
// -----------------------------------------------------------------------------
module tb_error_injection_sequencer;

    localparam int SEQ    = 3;
    localparam int DEPTH  = 3;
    localparam int P      = 3;
    localparam int BW     = 2;
    localparam int CH_W   = 8;
    localparam int W      = 9;
    localparam int CP     = 2;
    localparam int N_TAPS = SEQ + DEPTH - 1;
    // Accept cycle t ends at the accept edge; out_valid is high in cycle t+P+1,
    // which begins P edges after the accept edge.
    localparam int LAT_EDGES = P;

    logic                      clk = 1'b0;
    logic                      rstb = 1'b0;
    logic                      in_valid = 1'b0;
    logic                      in_ready;
    logic [N_TAPS*CH_W-1:0]    channel = '0;
    logic [P*DEPTH*BW-1:0]     trellis_patterns = '0;
    logic [P-1:0]              pattern_enable = '0;
    logic                      nrz_mode = 1'b0;
    logic                      out_valid;
    logic                      out_ready = 1'b0;
    logic [2*P*SEQ*W-1:0]      injection_error_seqs;
    logic                      sat_flag;

    int checks   = 0;
    int failures = 0;

    int ch_m[N_TAPS];
    int pat_m[P][DEPTH];
    bit en_m[P];
    bit nrz_m;
    int exp_bank[2*P][SEQ];
    bit exp_sat;

    always #5 clk = ~clk;

    error_injection_sequencer #(
        .seq_length              (SEQ),
        .trellis_pattern_depth   (DEPTH),
        .num_of_trellis_patterns (P),
        .branch_bitwidth         (BW),
        .est_channel_bitwidth    (CH_W),
        .est_err_bitwidth        (W),
        .cp                      (CP)
    ) dut (
        .clk                  (clk),
        .rstb                 (rstb),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .channel              (channel),
        .trellis_patterns     (trellis_patterns),
        .pattern_enable       (pattern_enable),
        .nrz_mode             (nrz_mode),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .injection_error_seqs (injection_error_seqs),
        .sat_flag             (sat_flag)
    );

    task automatic check(input string tag, input logic signed [31:0] observed,
                         input logic signed [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic logic signed [31:0] dut_out(input int r, input int j);
        logic signed [W-1:0] v;
        v = injection_error_seqs[(r*SEQ + j)*W +: W];
        return 32'(v);
    endfunction

    function automatic int clamp(input int v);
        int hi;
        int lo;
        hi = 2**(W-1) - 1;
        lo = -(2**(W-1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < N_TAPS; i++) ch_m[i] = 0;
        for (int p = 0; p < P; p++) begin
            en_m[p] = 1'b1;
            for (int k = 0; k < DEPTH; k++) pat_m[p][k] = 0;
        end
        nrz_m = 1'b0;
    endtask

    task automatic set_plan1();
        clear_model();
        ch_m[2] = 16;
        ch_m[3] = 8;
        ch_m[4] = 2;
        pat_m[0][0] = 1;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N_TAPS; i++) channel[i*CH_W +: CH_W] = CH_W'(ch_m[i]);
        for (int p = 0; p < P; p++) begin
            pattern_enable[p] = en_m[p];
            for (int k = 0; k < DEPTH; k++)
                trellis_patterns[(p*DEPTH + k)*BW +: BW] = BW'(pat_m[p][k]);
        end
        nrz_mode = nrz_m;
    endtask

    // Expected bank straight from the arithmetic definition of the sequences.
    task automatic model();
        int scale;
        int s;
        int idx;
        scale   = nrz_m ? 3 : 1;
        exp_sat = 1'b0;
        for (int p = 0; p < P; p++) begin
            for (int j = 0; j < SEQ; j++) begin
                s = 0;
                if (en_m[p]) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        idx = CP - k + j;
                        if (idx >= 0 && idx < N_TAPS) s += scale * pat_m[p][k] * 2 * ch_m[idx];
                    end
                end
                exp_bank[2*p][j]   = clamp(s);
                exp_bank[2*p+1][j] = clamp(-s);
                if (clamp(s) != s || clamp(-s) != -s) exp_sat = 1'b1;
            end
        end
    endtask

    task automatic check_bank(input string tag);
        for (int r = 0; r < 2*P; r++)
            for (int j = 0; j < SEQ; j++)
                check($sformatf("%s_r%0dj%0d", tag, r, j), dut_out(r, j), exp_bank[r][j]);
        check({tag, "_sat"}, 32'(sat_flag), 32'(exp_sat));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 1);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_sat"}, 32'(sat_flag), 0);
        for (int r = 0; r < 2*P; r++)
            for (int j = 0; j < SEQ; j++)
                check($sformatf("%s_zero_r%0dj%0d", tag, r, j), dut_out(r, j), 0);
    endtask

    // Issues one transaction from the model arrays and checks latency and bank.
    task automatic run_txn(input string tag);
        int lat;
        logic [63:0] junk;
        model();
        drive_inputs();
        in_valid = 1'b1;
        check({tag, "_in_ready"}, 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        // Disturb the live inputs: results must come from the captured copies.
        junk             = {$urandom(), $urandom()};
        channel          = junk[N_TAPS*CH_W-1:0];
        trellis_patterns = junk[63 -: P*DEPTH*BW];
        pattern_enable   = ~pattern_enable;
        nrz_mode         = ~nrz_mode;
        check({tag, "_busy"}, 32'(in_ready), 0);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, LAT_EDGES);
        check_bank(tag);
    endtask

    task automatic release_bank(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_rel_out_valid"}, 32'(out_valid), 0);
        check({tag, "_rel_in_ready"}, 32'(in_ready), 1);
        check({tag, "_rel_hold"}, dut_out(0, 0), exp_bank[0][0]);
    endtask

    initial begin
        int first_edge;
        int second_edge;

        // Reset
        tick();
        tick();
        check_reset_state("reset");
        rstb = 1'b1;
        tick();

        // 1: defaults
        set_plan1();
        run_txn("t1");
        check("t1_r0j0", dut_out(0, 0), 32);
        check("t1_r0j1", dut_out(0, 1), 16);
        check("t1_r0j2", dut_out(0, 2), 4);
        check("t1_r1j0", dut_out(1, 0), -32);
        check("t1_r1j2", dut_out(1, 2), -4);
        check("t1_r2j0", dut_out(2, 0), 0);
        release_bank("t1");

        // 2: NRZ scaling
        set_plan1();
        nrz_m = 1'b1;
        run_txn("t2");
        check("t2_r0j0", dut_out(0, 0), 96);
        check("t2_r1j2", dut_out(1, 2), -12);
        check("t2_sat_const", 32'(sat_flag), 0);
        release_bank("t2");

        // 3: saturation on both rails
        clear_model();
        for (int i = 0; i < N_TAPS; i++) ch_m[i] = 127;
        for (int k = 0; k < DEPTH; k++) pat_m[0][k] = 1;
        nrz_m = 1'b1;
        run_txn("t3");
        check("t3_r0j0", dut_out(0, 0), 255);
        check("t3_r1j0", dut_out(1, 0), -256);
        check("t3_sat_const", 32'(sat_flag), 1);
        release_bank("t3");

        // 4: tap index 0 is included; disabled pattern writes zeros
        clear_model();
        ch_m[0] = 5;
        pat_m[0][2] = 1;
        run_txn("t4");
        check("t4_r0j0", dut_out(0, 0), 10);
        check("t4_r1j0", dut_out(1, 0), -10);
        release_bank("t4");
        en_m[0] = 1'b0;
        run_txn("t4_dis");
        check("t4_dis_r0j0", dut_out(0, 0), 0);
        release_bank("t4_dis");

        // 5: backpressure with in_valid pulsing
        set_plan1();
        run_txn("t5");
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            channel  = N_TAPS*CH_W'($urandom());
            tick();
            check($sformatf("t5_hold_valid%0d", c), 32'(out_valid), 1);
            check($sformatf("t5_hold_busy%0d", c), 32'(in_ready), 0);
        end
        in_valid = 1'b0;
        check_bank("t5_hold");
        release_bank("t5");
        for (int c = 0; c < 6; c++) tick();
        check("t5_no_second_valid", 32'(out_valid), 0);
        check("t5_no_second_ready", 32'(in_ready), 1);

        // 6: reset during CALC with p=1
        set_plan1();
        model();
        drive_inputs();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("t6_row0_written", dut_out(0, 0), 32);
        #2;
        rstb = 1'b0;
        #1;
        check_reset_state("t6_rst");
        @(negedge clk);
        rstb = 1'b1;
        tick();
        run_txn("t6_after");
        release_bank("t6_after");

        // Random transactions
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < N_TAPS; i++) ch_m[i] = int'($urandom_range(0, 255)) - 128;
            for (int p = 0; p < P; p++) begin
                en_m[p] = 1'($urandom_range(0, 3) != 0);
                for (int k = 0; k < DEPTH; k++) pat_m[p][k] = int'($urandom_range(0, 3)) - 2;
            end
            nrz_m = 1'($urandom_range(0, 1));
            run_txn($sformatf("rnd%0d", n));
            release_bank($sformatf("rnd%0d", n));
        end

        // Throughput with both handshakes held high
        set_plan1();
        drive_inputs();
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        first_edge  = -1;
        second_edge = -1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (out_valid === 1'b1) begin
                if (first_edge < 0) first_edge = e;
                else if (second_edge < 0) second_edge = e;
            end
        end
        check("thru_period", second_edge - first_edge, P + 2);
        in_valid = 1'b0;
        for (int e = 0; e < 20 && in_ready !== 1'b1; e++) tick();
        out_ready = 1'b0;
        check("thru_idle", 32'(in_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
